// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, functs,
// ALU-op classes, ALU control codes and the control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       regdst;
        logic       branch_eq;
        logic       branch_ne;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU with zero flag.
module alu_core
    import mips_pkg::*;
(
    input  logic [3:0]  ctl_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [31:0] out_o,
    output logic        zero_o
);

    always_comb begin
        out_o = 32'h0;
        case (ctl_i)
            ALU_AND: out_o = op1_i & op2_i;
            ALU_OR:  out_o = op1_i | op2_i;
            ALU_ADD: out_o = op1_i + op2_i;
            ALU_SUB: out_o = op1_i - op2_i;
            ALU_SLT: out_o = {31'b0, $signed(op1_i) < $signed(op2_i)};
            ALU_NOR: out_o = ~(op1_i | op2_i);
            default: out_o = 32'h0;
        endcase
    end

    assign zero_o = (out_o == 32'h0);

endmodule

// File: rtl/exec_decode_unit.sv
// Registered decode-and-execute stage: main control, ALU control, operand mux
// and ALU, with every output captured in a single register stage.
module exec_decode_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        regdst,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrc,
    output logic        jump,
    output logic [1:0]  aluop,
    output logic [3:0]  aluctl,
    output logic [31:0] result,
    output logic        zero
);

    ctrl_t       ctrl_d, ctrl_q;
    logic [3:0]  aluctl_d, aluctl_q;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic [31:0] op2;
    logic        unused_inst;

    // Register-number fields are consumed elsewhere in the pipeline.
    assign unused_inst = ^inst[25:16];

    always_comb begin
        ctrl_d = '0;
        case (inst[31:26])
            OP_RTYPE: begin
                ctrl_d.regdst   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_d.memread  = 1'b1;
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
            end
            OP_SW: begin
                ctrl_d.memwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch_eq = 1'b1;
                ctrl_d.aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl_d.branch_ne = 1'b1;
                ctrl_d.aluop     = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
            end
            OP_J:    ctrl_d.jump = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_comb begin
        aluctl_d = ALU_AND;
        case (ctrl_d.aluop)
            ALUOP_ADD: aluctl_d = ALU_ADD;
            ALUOP_SUB: aluctl_d = ALU_SUB;
            ALUOP_FUNCT: begin
                case (inst[5:0])
                    FN_ADD:  aluctl_d = ALU_ADD;
                    FN_SUB:  aluctl_d = ALU_SUB;
                    FN_AND:  aluctl_d = ALU_AND;
                    FN_OR:   aluctl_d = ALU_OR;
                    FN_NOR:  aluctl_d = ALU_NOR;
                    FN_SLT:  aluctl_d = ALU_SLT;
                    default: aluctl_d = ALU_AND;
                endcase
            end
            default: aluctl_d = ALU_AND;
        endcase
    end

    assign op2 = ctrl_d.alusrc ? {{16{inst[15]}}, inst[15:0]} : b;

    alu_core u_alu (
        .ctl_i  (aluctl_d),
        .op1_i  (a),
        .op2_i  (op2),
        .out_o  (result_d),
        .zero_o (zero_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            aluctl_q <= 4'h0;
            result_q <= 32'h0;
            zero_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            aluctl_q <= aluctl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign regdst    = ctrl_q.regdst;
    assign branch_eq = ctrl_q.branch_eq;
    assign branch_ne = ctrl_q.branch_ne;
    assign memread   = ctrl_q.memread;
    assign memwrite  = ctrl_q.memwrite;
    assign memtoreg  = ctrl_q.memtoreg;
    assign regwrite  = ctrl_q.regwrite;
    assign alusrc    = ctrl_q.alusrc;
    assign jump      = ctrl_q.jump;
    assign aluop     = ctrl_q.aluop;
    assign aluctl    = aluctl_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_exec_decode_unit.sv
// Scoreboard bench for exec_decode_unit: stimulus pushes expected outputs from
// an instruction-level reference model, a monitor pops and compares each cycle.
module tb_exec_decode_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst = 32'h0, a = 32'h0, b = 32'h0;
    logic        regdst, branch_eq, branch_ne, memread, memwrite, memtoreg;
    logic        regwrite, alusrc, jump, zero;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        bit [8:0]   ctl;   // {regdst,beq,bne,memread,memwrite,memtoreg,regwrite,alusrc,jump}
        bit [1:0]   aluop;
        bit [3:0]   aluctl;
        bit [31:0]  result;
        bit         zero;
    } exp_t;

    exp_t exp_q[$];

    exec_decode_unit dut (
        .clk       (clk),
        .reset     (reset),
        .inst      (inst),
        .a         (a),
        .b         (b),
        .regdst    (regdst),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .memread   (memread),
        .memwrite  (memwrite),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrc    (alusrc),
        .jump      (jump),
        .aluop     (aluop),
        .aluctl    (aluctl),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Instruction-level meaning: what each instruction computes, straight from its semantics.
    function automatic exp_t model(input string nm, input logic [31:0] i,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [31:0] sx;
        sx = {{16{i[15]}}, i[15:0]};
        e.name = nm;
        e.ctl = 9'b0;
        e.aluop = 2'd0;
        e.aluctl = 4'd2;
        e.result = x + y;
        case (i[31:26])
            6'd0: begin
                e.ctl = 9'b100000100;
                e.aluop = 2'd2;
                case (i[5:0])
                    6'd32: begin e.aluctl = 4'd2;  e.result = x + y;      end
                    6'd34: begin e.aluctl = 4'd6;  e.result = x - y;      end
                    6'd36: begin e.aluctl = 4'd0;  e.result = x & y;      end
                    6'd37: begin e.aluctl = 4'd1;  e.result = x | y;      end
                    6'd39: begin e.aluctl = 4'd12; e.result = ~(x | y);   end
                    6'd42: begin
                        e.aluctl = 4'd7;
                        e.result = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    end
                    default: begin e.aluctl = 4'd0; e.result = x & y;     end
                endcase
            end
            6'd35: begin e.ctl = 9'b000101110; e.result = x + sx; end
            6'd43: begin e.ctl = 9'b000010010; e.result = x + sx; end
            6'd4:  begin e.ctl = 9'b010000000; e.aluop = 2'd1; e.aluctl = 4'd6; e.result = x - y; end
            6'd5:  begin e.ctl = 9'b001000000; e.aluop = 2'd1; e.aluctl = 4'd6; e.result = x - y; end
            6'd8:  begin e.ctl = 9'b000000110; e.result = x + sx; end
            6'd2:  e.ctl = 9'b000000001;
            default: ;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Drive one instruction now (caller is already at a negedge) and log its expectation.
    task automatic drive(input string nm, input logic [31:0] i,
                         input logic [31:0] x, input logic [31:0] y);
        inst = i;
        a = x;
        b = y;
        exp_q.push_back(model(nm, i, x, y));
    endtask

    task automatic issue(input string nm, input logic [31:0] i,
                         input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        drive(nm, i, x, y);
    endtask

    task automatic check_all_zero(input string nm);
        logic [50:0] v;
        v = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite,
             alusrc, jump, aluop, aluctl, result, zero};
        checks++;
        if (v !== 51'd0) begin
            errors++;
            $display("FAIL %s: outputs got %h want 0", nm, v);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare one expectation per edge.
    initial begin
        exp_t     e;
        bit [8:0] got_ctl;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_ctl = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                           regwrite, alusrc, jump};
                checks += 4;
                if (got_ctl !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got %b want %b", e.name, got_ctl, e.ctl);
                end
                if ({aluop, aluctl} !== {e.aluop, e.aluctl}) begin
                    errors++;
                    $display("FAIL %s aluop/aluctl: got %b/%b want %b/%b",
                             e.name, aluop, aluctl, e.aluop, e.aluctl);
                end
                if (result !== e.result) begin
                    errors++;
                    $display("FAIL %s result: got %h want %h", e.name, result, e.result);
                end
                if (zero !== e.zero) begin
                    errors++;
                    $display("FAIL %s zero: got %b want %b", e.name, zero, e.zero);
                end
            end
        end
    end

    logic [5:0] ops [9] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2, 6'd63, 6'd17};
    logic [5:0] fns [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd7};

    initial begin
        logic [5:0]  op, fn;
        logic [31:0] ra, rb;
        #1 reset = 1'b1;
        #1 check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_held");
        @(negedge clk);
        reset = 1'b0;

        issue("add",      rtype(6'd32), 32'd5, 32'd7);
        issue("sub_eq",   rtype(6'd34), 32'h1234, 32'h1234);
        issue("slt_neg",  rtype(6'd42), 32'hFFFF_FFFF, 32'd1);
        issue("slt_swap", rtype(6'd42), 32'd1, 32'hFFFF_FFFF);
        issue("lw",       itype(6'd35, 16'hFFFC), 32'd100, 32'd999);
        issue("sw",       itype(6'd43, 16'hFFFC), 32'd100, 32'd999);
        issue("beq",      itype(6'd4, 16'h0010), 32'd7, 32'd7);
        issue("bne",      itype(6'd5, 16'h0010), 32'd7, 32'd8);
        issue("j",        {6'd2, 26'h123_4567}, 32'd9, 32'd4);
        issue("illegal",  itype(6'd63, 16'h8001), 32'd10, 32'd20);
        issue("bad_fn",   rtype(6'd7), 32'd3, 32'd5);
        issue("addi",     itype(6'd8, 16'h7FFF), 32'hFFFF_0000, 32'd1);
        issue("or",       rtype(6'd37), 32'hF0F0_0000, 32'h0000_0F0F);
        issue("nor",      rtype(6'd39), 32'hFFFF_0000, 32'h0000_FFFF);

        // Mid-stream reset: the instruction driven this cycle is discarded.
        issue("pre_rst",  rtype(6'd32), 32'd1, 32'd2);
        issue("lost",     rtype(6'd34), 32'd9, 32'd2);
        void'(exp_q.pop_back());
        #2 reset = 1'b1;
        #1 check_all_zero("reset_midstream");
        @(posedge clk);
        #1 check_all_zero("reset_ignores_inputs");
        @(negedge clk);
        reset = 1'b0;
        drive("post_rst", itype(6'd35, 16'h0004), 32'd40, 32'd0);

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 6'd17) op = 6'($urandom);
            fn = fns[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            rb = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? rb : $urandom;
            if (op == 6'd0)
                issue("rand_r", {6'd0, 20'($urandom), fn}, ra, rb);
            else
                issue("rand_i", {op, 10'($urandom), 16'($urandom)}, ra, rb);
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
